imem_resp: RTL

Instruction memory responder for the single-cycle RISC-V core: the fetch-side counterpart of the program counter register. It accepts the current instruction address from the PC, returns the 32-bit instruction word combinationally in the same cycle, and flags misaligned or out-of-range fetches. Before execution, a word-serial loader port fills the array with program image data.

---
 rtl/imem_resp_if.sv | 43 ++++
 rtl/imem_resp.sv | 127 ++++++++++++
 2 files changed

// File: rtl/imem_resp_if.sv
`default_nettype none
// ============================================================================
// Module      : imem_resp_if
// Description : Fetch/loader bundle between the PC side, the program loader
//               and the instruction memory responder.
//               master : drives pc_addr and the loader/reload controls
//               slave  : returns the instruction, validity, fault flags and
//                        loader progress
// Revision    : 1.0 - initial release
// ============================================================================
interface imem_resp_if #(
  parameter int pc_width    = 32,
  parameter int instr_width = 32,
  parameter int depth_words = 256
);
  localparam int c_cnt_width = $clog2(depth_words) + 1;

  logic [pc_width-1:0]    pc_addr;
  logic [instr_width-1:0] instr_out;
  logic                   instr_valid;
  logic                   misalign_fault;
  logic                   oob_fault;
  logic [pc_width-1:0]    fault_addr;
  logic                   load_valid;
  logic [instr_width-1:0] load_data;
  logic                   load_last;
  logic                   load_ready;
  logic [c_cnt_width-1:0] load_count;
  logic                   reload_req;

  modport master (
    output pc_addr, load_valid, load_data, load_last, reload_req,
    input  instr_out, instr_valid, misalign_fault, oob_fault, fault_addr,
           load_ready, load_count
  );

  modport slave (
    input  pc_addr, load_valid, load_data, load_last, reload_req,
    output instr_out, instr_valid, misalign_fault, oob_fault, fault_addr,
           load_ready, load_count
  );
endinterface
`default_nettype wire

// File: rtl/imem_resp.sv
`default_nettype none
// ============================================================================
// Module      : imem_resp
// Description : Instruction memory responder. A word-serial loader fills the
//               array in LOAD; in RUN the word addressed by pc_addr is
//               returned combinationally. Misaligned fetches trap into a
//               sticky FAULT state that only reset leaves.
// Ports       : clk_150_mhz - core clock, rising edge
//               imem_rst    - synchronous active-high reset
//               bus         - imem_resp_if slave (fetch, loader, status)
// Revision    : 1.0 - initial release
// ============================================================================
module imem_resp #(
  parameter int pc_width    = 32,
  parameter int instr_width = 32,
  parameter int depth_words = 256
) (
  input  wire logic  clk_150_mhz,
  input  wire logic  imem_rst,
  imem_resp_if.slave bus
);
  localparam int c_aw = $clog2(depth_words);
  localparam int c_cw = c_aw + 1;
  localparam logic [instr_width-1:0] c_nop = instr_width'(32'h0000_0013);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [c_cw-1:0]     load_count_q, load_count_d;
  logic                misalign_q, misalign_d;
  logic [pc_width-1:0] fault_addr_q, fault_addr_d;

  // Program image; intentionally not reset so it survives imem_rst.
  logic [instr_width-1:0] mem_q [depth_words];

  logic            w_misaligned;
  logic            w_oob;
  logic            w_load_accept;
  logic            w_last_slot;
  logic [c_aw-1:0] w_index;

  assign w_misaligned  = (bus.pc_addr[1:0] != 2'b00);
  // Full-address range check: any set bit above the index field is out of range.
  assign w_oob         = ((bus.pc_addr >> 2) >= pc_width'(depth_words));
  assign w_index       = bus.pc_addr[c_aw+1:2];
  assign w_load_accept = (state_q == ST_LOAD) && bus.load_valid;
  assign w_last_slot   = (load_count_q == c_cw'(depth_words - 1));

  always_ff @(posedge clk_150_mhz) begin
    if (imem_rst) begin
      state_q      <= ST_LOAD;
      load_count_q <= '0;
      misalign_q   <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      load_count_q <= load_count_d;
      misalign_q   <= misalign_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  // A word presented together with reset is dropped.
  always_ff @(posedge clk_150_mhz) begin
    if (!imem_rst && w_load_accept) begin
      mem_q[load_count_q[c_aw-1:0]] <= bus.load_data;
    end
  end

  always_comb begin
    state_d      = state_q;
    load_count_d = load_count_q;
    misalign_d   = misalign_q;
    fault_addr_d = fault_addr_q;
    case (state_q)
      ST_LOAD: begin
        if (bus.load_valid) begin
          load_count_d = load_count_q + c_cw'(1);
          if (bus.load_last || w_last_slot) begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        // Misalignment wins over both out-of-range and reload.
        if (w_misaligned) begin
          state_d      = ST_FAULT;
          misalign_d   = 1'b1;
          fault_addr_d = bus.pc_addr;
        end else if (bus.reload_req) begin
          state_d      = ST_LOAD;
          load_count_d = '0;
        end
      end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_LOAD;
    endcase
  end

  always_comb begin
    bus.instr_out   = c_nop;
    bus.instr_valid = 1'b0;
    bus.oob_fault   = 1'b0;
    bus.load_ready  = 1'b0;
    case (state_q)
      ST_LOAD: bus.load_ready = 1'b1;
      ST_RUN: begin
        bus.oob_fault = w_oob;
        if (!w_misaligned && !w_oob) begin
          bus.instr_out   = mem_q[w_index];
          bus.instr_valid = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.misalign_fault = misalign_q;
  assign bus.fault_addr     = fault_addr_q;
  assign bus.load_count     = load_count_q;

endmodule
`default_nettype wire
